// File: rtl/tetris_input_ctrl.sv
// Button front-end for the Tetris game FSM: press/auto-repeat event generation, priority arbitration, valid/ready issue.
// Optional macro TETRIS_INPUT_OPPOSE_CANCEL_EN: holding left and right together suppresses their auto-repeat.
module tetris_input_ctrl #(
    parameter int DAS_CYCLES = 2_500_000,
    parameter int ARR_CYCLES = 500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] btn,
    input  logic       hold,
    output logic       cmd_valid,
    output logic [2:0] cmd_code,
    input  logic       cmd_ready,
    output logic [7:0] drop_cnt
);
    localparam int MAX_CYC = (DAS_CYCLES > ARR_CYCLES) ? DAS_CYCLES : ARR_CYCLES;
    localparam int CW = $clog2(MAX_CYC);
    localparam logic [CW-1:0] DAS_TC = CW'(DAS_CYCLES - 1);
    localparam logic [CW-1:0] ARR_TC = CW'(ARR_CYCLES - 1);

    typedef enum logic [1:0] {RPT_IDLE, RPT_DELAY, RPT_REPEAT} rpt_state_t;

    rpt_state_t    state_q [3];
    rpt_state_t    state_d [3];
    logic [CW-1:0] cnt_q [3];
    logic [CW-1:0] cnt_d [3];

    logic [5:0] btn_q;
    logic [5:0] pending_q, pending_d;
    logic [5:0] press, ev, sel_pend, xfer, lost;
    logic [2:0] rpt, start;
    logic [2:0] sel_idx, n_lost;
    logic [8:0] drop_sum;
    logic [7:0] drop_d;
    logic       sel_any, load, cancel;

    always_comb begin
        press  = btn & ~btn_q;
        start  = press[2:0];
        cancel = 1'b0;
`ifdef TETRIS_INPUT_OPPOSE_CANCEL_EN
        cancel   = btn[0] & btn[1];
        // Releasing the opposing button restarts DAS on the one still held.
        start[0] = press[0] | (btn[0] & btn_q[0] & btn_q[1] & ~btn[1]);
        start[1] = press[1] | (btn[1] & btn_q[1] & btn_q[0] & ~btn[0]);
`endif
        for (int i = 0; i < 3; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            rpt[i]     = 1'b0;
            if (!btn[i] || hold || (cancel && i < 2)) begin
                state_d[i] = RPT_IDLE;
                cnt_d[i]   = '0;
            end else begin
                case (state_q[i])
                    RPT_IDLE: begin
                        if (start[i]) begin
                            state_d[i] = RPT_DELAY;
                            cnt_d[i]   = '0;
                        end
                    end
                    RPT_DELAY: begin
                        if (cnt_q[i] == DAS_TC) begin
                            rpt[i]     = 1'b1;
                            state_d[i] = RPT_REPEAT;
                            cnt_d[i]   = '0;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CW'(1);
                        end
                    end
                    RPT_REPEAT: begin
                        if (cnt_q[i] == ARR_TC) begin
                            rpt[i]   = 1'b1;
                            cnt_d[i] = '0;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CW'(1);
                        end
                    end
                    default: begin
                        state_d[i] = RPT_IDLE;
                        cnt_d[i]   = '0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        ev = press | {3'b000, rpt};
        if (hold) ev[4:0] = '0;
        sel_pend = hold ? {pending_q[5], 5'b00000} : pending_q;
        load     = !cmd_valid || cmd_ready;
        sel_any  = |sel_pend;
        sel_idx  = '0;
        for (int i = 0; i < 6; i++) begin
            if (sel_pend[i]) sel_idx = 3'(i);
        end
        xfer = (load && sel_any) ? (6'b000001 << sel_idx) : 6'b000000;
        // A set on the same edge as its transfer wins, so it is not a loss.
        pending_d = ev | (pending_q & ~xfer);
        if (hold) pending_d[4:0] = '0;
        lost   = ev & pending_q & ~xfer;
        n_lost = '0;
        for (int i = 0; i < 6; i++) begin
            n_lost = n_lost + 3'(lost[i]);
        end
        drop_sum = {1'b0, drop_cnt} + 9'(n_lost);
        drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_q     <= '0;
            pending_q <= '0;
            drop_cnt  <= '0;
            cmd_valid <= 1'b0;
            cmd_code  <= '0;
            for (int i = 0; i < 3; i++) begin
                state_q[i] <= RPT_IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            btn_q     <= btn;
            pending_q <= pending_d;
            drop_cnt  <= drop_d;
            for (int i = 0; i < 3; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            if (load) begin
                cmd_valid <= sel_any;
                if (sel_any) cmd_code <= sel_idx;
            end
        end
    end
endmodule

// File: tb/tb_tetris_input_ctrl.sv
// Directed bench for tetris_input_ctrl with DAS_CYCLES=4, ARR_CYCLES=2.
module tb_tetris_input_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] btn;
    logic       hold;
    logic       cmd_valid;
    logic [2:0] cmd_code;
    logic       cmd_ready;
    logic [7:0] drop_cnt;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    int q_code[$];
    int q_cyc[$];

    tetris_input_ctrl #(.DAS_CYCLES(4), .ARR_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .btn(btn), .hold(hold),
        .cmd_valid(cmd_valid), .cmd_code(cmd_code),
        .cmd_ready(cmd_ready), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Handshakes seen at the negative edge complete on the following rising edge.
    always @(negedge clk) begin
        if (!rst && cmd_valid && cmd_ready) begin
            q_code.push_back(int'(cmd_code));
            q_cyc.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; btn = '0; hold = 1'b0; cmd_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        q_code.delete();
        q_cyc.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; btn = '0; hold = 1'b0; cmd_ready = 1'b0;
        repeat (2) tick();
        vectors++;
        if (cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", cmd_valid); end
        vectors++;
        if (cmd_code !== 3'd0) begin errors++; $display("FAIL reset_code got %0d want 0", cmd_code); end
        vectors++;
        if (drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop got %0d want 0", drop_cnt); end
    endtask

    task automatic test_single_press();
        int base;
        do_reset();
        cmd_ready = 1'b1;
        base = cyc;
        btn = 6'b001000;
        repeat (8) tick();
        btn = '0;
        vectors++;
        if (q_code.size() !== 1) begin errors++; $display("FAIL single_count got %0d want 1", q_code.size()); end
        else begin
            vectors++;
            if (q_code[0] !== 3) begin errors++; $display("FAIL single_code got %0d want 3", q_code[0]); end
            vectors++;
            if (q_cyc[0] !== base + 2) begin errors++; $display("FAIL single_latency got %0d want %0d", q_cyc[0] - base, 2); end
        end
        vectors++;
        if (drop_cnt !== 8'd0) begin errors++; $display("FAIL single_drop got %0d want 0", drop_cnt); end
    endtask

    task automatic test_left_repeat();
        int base;
        int offs[5] = '{2, 6, 8, 10, 12};
        do_reset();
        cmd_ready = 1'b1;
        base = cyc;
        btn = 6'b000001;
        repeat (12) tick();
        btn = '0;
        repeat (6) tick();
        vectors++;
        if (q_code.size() !== 5) begin errors++; $display("FAIL repeat_count got %0d want 5", q_code.size()); end
        for (int k = 0; k < 5 && k < q_code.size(); k++) begin
            vectors++;
            if (q_code[k] !== 0 || q_cyc[k] !== base + offs[k]) begin
                errors++;
                $display("FAIL repeat_evt%0d got code %0d at +%0d want code 0 at +%0d", k, q_code[k], q_cyc[k] - base, offs[k]);
            end
        end
        vectors++;
        if (drop_cnt !== 8'd0) begin errors++; $display("FAIL repeat_drop got %0d want 0", drop_cnt); end
    endtask

    task automatic test_all_buttons();
        int base;
        do_reset();
        btn = 6'b111111;
        tick();
        btn = '0;
        for (int k = 0; k < 5; k++) begin
            tick();
            vectors++;
            if ({cmd_valid, cmd_code} !== 4'b1101) begin
                errors++;
                $display("FAIL stall%0d got valid %b code %0d want valid 1 code 5", k, cmd_valid, cmd_code);
            end
        end
        cmd_ready = 1'b1;
        base = cyc;
        repeat (8) tick();
        vectors++;
        if (q_code.size() !== 6) begin errors++; $display("FAIL all_count got %0d want 6", q_code.size()); end
        for (int k = 0; k < 6 && k < q_code.size(); k++) begin
            vectors++;
            if (q_code[k] !== 5 - k || q_cyc[k] !== base + k) begin
                errors++;
                $display("FAIL all_seq%0d got code %0d at +%0d want code %0d at +%0d", k, q_code[k], q_cyc[k] - base, 5 - k, k);
            end
        end
        vectors++;
        if (drop_cnt !== 8'd0) begin errors++; $display("FAIL all_drop got %0d want 0", drop_cnt); end
    endtask

    task automatic test_coalesce();
        do_reset();
        btn = 6'b001000;
        tick();
        btn = '0;
        tick();
        for (int k = 0; k < 3; k++) begin
            btn = 6'b010000;
            tick();
            btn = '0;
            tick();
        end
        vectors++;
        if (drop_cnt !== 8'd2) begin errors++; $display("FAIL coalesce_drop got %0d want 2", drop_cnt); end
        vectors++;
        if ({cmd_valid, cmd_code} !== 4'b1011) begin
            errors++; $display("FAIL coalesce_hold got valid %b code %0d want valid 1 code 3", cmd_valid, cmd_code);
        end
        cmd_ready = 1'b1;
        repeat (6) tick();
        vectors++;
        if (q_code.size() !== 2) begin errors++; $display("FAIL coalesce_count got %0d want 2", q_code.size()); end
        else begin
            vectors++;
            if (q_code[0] !== 3 || q_code[1] !== 4) begin
                errors++; $display("FAIL coalesce_codes got %0d,%0d want 3,4", q_code[0], q_code[1]);
            end
        end
    endtask

    task automatic test_hold();
        do_reset();
        cmd_ready = 1'b1;
        hold = 1'b1;
        btn = 6'b100010;
        tick();
        btn = '0;
        repeat (5) tick();
        hold = 1'b0;
        repeat (4) tick();
        vectors++;
        if (q_code.size() !== 1) begin errors++; $display("FAIL hold_count got %0d want 1", q_code.size()); end
        else begin
            vectors++;
            if (q_code[0] !== 5) begin errors++; $display("FAIL hold_code got %0d want 5", q_code[0]); end
        end
        vectors++;
        if (drop_cnt !== 8'd0) begin errors++; $display("FAIL hold_drop got %0d want 0", drop_cnt); end
    endtask

    task automatic test_oppose();
        int base;
`ifdef TETRIS_INPUT_OPPOSE_CANCEL_EN
        int n = 2;
        int codes[8] = '{1, 0, 0, 0, 0, 0, 0, 0};
        int offs[8]  = '{2, 3, 0, 0, 0, 0, 0, 0};
`else
        int n = 8;
        int codes[8] = '{1, 0, 1, 0, 1, 0, 1, 0};
        int offs[8]  = '{2, 3, 6, 7, 8, 9, 10, 11};
`endif
        do_reset();
        cmd_ready = 1'b1;
        base = cyc;
        btn = 6'b000011;
        repeat (10) tick();
        btn = '0;
        repeat (6) tick();
        vectors++;
        if (q_code.size() !== n) begin errors++; $display("FAIL oppose_count got %0d want %0d", q_code.size(), n); end
        for (int k = 0; k < n && k < q_code.size(); k++) begin
            vectors++;
            if (q_code[k] !== codes[k] || q_cyc[k] !== base + offs[k]) begin
                errors++;
                $display("FAIL oppose_evt%0d got code %0d at +%0d want code %0d at +%0d", k, q_code[k], q_cyc[k] - base, codes[k], offs[k]);
            end
        end
        vectors++;
        if (drop_cnt !== 8'd0) begin errors++; $display("FAIL oppose_drop got %0d want 0", drop_cnt); end
    endtask

    task automatic test_saturate_and_midreset();
        do_reset();
        btn = 6'b001000;
        tick();
        btn = '0;
        tick();
        for (int k = 0; k < 300; k++) begin
            btn = 6'b100000;
            tick();
            btn = '0;
            tick();
        end
        vectors++;
        if (drop_cnt !== 8'd255) begin errors++; $display("FAIL saturate_drop got %0d want 255", drop_cnt); end
        vectors++;
        if (cmd_valid !== 1'b1) begin errors++; $display("FAIL saturate_valid got %b want 1", cmd_valid); end
        rst = 1'b1;
        tick();
        vectors++;
        if (cmd_valid !== 1'b0 || drop_cnt !== 8'd0) begin
            errors++; $display("FAIL midreset got valid %b drop %0d want valid 0 drop 0", cmd_valid, drop_cnt);
        end
        rst = 1'b0;
        q_code.delete();
        q_cyc.delete();
        cmd_ready = 1'b1;
        repeat (5) tick();
        vectors++;
        if (q_code.size() !== 0) begin errors++; $display("FAIL midreset_lost got %0d issued want 0", q_code.size()); end
    endtask

    initial begin
        rst = 1'b1; btn = '0; hold = 1'b0; cmd_ready = 1'b0;
        test_reset();
        test_single_press();
        test_left_repeat();
        test_all_buttons();
        test_coalesce();
        test_hold();
        test_oppose();
        test_saturate_and_midreset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/tetris_input_ctrl.md
Name: tetris_input_ctrl

Overview:
- Sits between the six per-button debounce instances and the Tetris game FSM.
- Turns debounced button levels into single-shot press events, with auto-repeat (DAS/ARR) on the left, right and soft-down buttons.
- Arbitrates the pending events by fixed priority and issues one command at a time to the game logic over a valid/ready handshake.

Parameters:
- DAS_CYCLES, 2_500_000: clk cycles a repeatable button must be held before its first repeat event (min 2).
- ARR_CYCLES, 500_000: clk cycles between subsequent repeat events (min 2).

Ports:
- clk  in  1  system clock, single clock domain
- rst  in  1  synchronous, active-high reset
- btn  in  6  debounced levels: [0] left, [1] right, [2] soft down, [3] rotate, [4] hard drop, [5] pause
- hold  in  1  game paused: only pause (btn[5]) events accepted
- cmd_valid  out  1  command available
- cmd_code  out  3  command = button index 0..5
- cmd_ready  in  1  game FSM accepts command
- drop_cnt  out  8  saturating count of coalesced (lost) events

Behaviour:
- Reset (synchronous, active-high): cmd_valid=0, cmd_code=0, drop_cnt=0, pending=0, btn_q=0, all repeat FSMs IDLE with count 0.
- Edge detect: btn_q registers btn every cycle. A press event for bit i is btn[i] & ~btn_q[i].
- Pending: a 6-bit register.
  - An event sets pending[i].
  - If pending[i] is already 1 and not being transferred on that edge, the event is coalesced and drop_cnt increments, saturating at 255.
  - If set and transfer of bit i happen on the same edge, set wins: pending[i] stays 1 and drop_cnt does not increment.
- Output register load condition: cmd_valid==0, or cmd_valid && cmd_ready on this edge.
  - When the condition holds and any pending bit is 1, load the highest index pending (pause highest, left lowest) into cmd_code, clear that pending bit, and set cmd_valid=1.
  - When the condition holds and no bit is pending, cmd_valid=0.
- Handshake stability: while cmd_valid && !cmd_ready, cmd_code and cmd_valid hold stable.
- Latency: first edge sampling btn[i]=1 with an empty pipeline → cmd_valid=1 after the second edge (2 cycles).
- Throughput: 1 command per cycle with cmd_ready held high.
- hold=1:
  - Events for bits 0–4 are discarded and do not count toward drop_cnt.
  - pending[4:0] is cleared every cycle.
  - An already-valid output command is never retracted.
  - Pause events continue normally.
- Repeat FSM, one each for bits 0,1,2 (states IDLE, DELAY, REPEAT; counter sized $clog2(max(DAS,ARR))):
  - IDLE → DELAY on a press event, cnt=0.
  - DELAY: cnt increments. At cnt==DAS_CYCLES-1, emit a repeat event, go to REPEAT, cnt=0.
  - REPEAT: at cnt==ARR_CYCLES-1, emit a repeat event, cnt=0; otherwise cnt increments.
  - btn[i]==0 or hold==1 in any state → IDLE, cnt=0 on that edge, no event.
  - Repeat events follow the same pending/coalesce rules as press events.
- Rotate, hard drop and pause never repeat.
- Simultaneous presses of several buttons: all pending bits set on the same edge; issued in descending index order on consecutive accepted cycles.
- rst mid-transaction: cmd_valid drops on the reset edge and all pending commands are lost.

Optional Feature:
- Macro: TETRIS_INPUT_OPPOSE_CANCEL_EN.
- Defined:
  - While btn[0] and btn[1] are both 1, both left/right repeat FSMs are forced to IDLE and emit no repeat events.
  - Press events still occur.
  - Releasing one of the two lets the held one restart DAS from cnt=0 on the next edge.
- Undefined: left and right repeat independently.

Test Plan (DAS_CYCLES=4, ARR_CYCLES=2):
- Reset, then btn[3] held 1 from cycle 0, cmd_ready=1 → exactly one cmd_code=3 with cmd_valid high in cycle 2 only; drop_cnt=0.
- btn[0] held for 12 cycles, cmd_ready=1 → code 0 issued once at the press, then one repeat 4 cycles after the press, then one every 2 cycles until release; none after release.
- btn=6'b111111 in one cycle, cmd_ready=0 for 5 cycles then 1 → cmd_code stays 5 while stalled, then 5,4,3,2,1,0 on consecutive cycles.
- cmd_ready=0, btn[4] pulsed (press, release, press) three times → one pending, drop_cnt=2; after ready, only one code 4 issued.
- hold=1, press btn[1] and btn[5] → only code 5 issued; drop_cnt unchanged.
- Macro defined: hold btn[0] and btn[1] together for 10 cycles → only the two press commands (codes 1, 0); no repeats. Macro undefined → repeats from both buttons.
